// File: rtl/dds_tuning_word_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_tuning_word_ctrl
// Brief    : Push-key driven DDS tuning word with debounce, auto-repeat,
//            saturation in [WORD_MIN, WORD_MAX] and a host load port.
// Revision : 1.0 - initial release
// ============================================================================
module dds_tuning_word_ctrl #(
    parameter int                     WIDTH        = 32,
    parameter int                     NSTEP        = 3,
    parameter logic [NSTEP*WIDTH-1:0] STEPS        = {32'd85, 32'd85899, 32'd858993},
    parameter logic [WIDTH-1:0]       WORD_INIT    = 32'd171798691,
    parameter logic [WIDTH-1:0]       WORD_MIN     = 32'd858993,
    parameter logic [WIDTH-1:0]       WORD_MAX     = 32'd171798691,
    parameter int                     DEBOUNCE_CYC = 500000,
    parameter int                     REPEAT_DELAY = 25000000,
    parameter int                     REPEAT_RATE  = 2500000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSTEP-1:0] key_add_n,
    input  logic [NSTEP-1:0] key_sub_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_word,
    output logic [WIDTH-1:0] tuning_word,
    output logic             word_upd,
    output logic             at_max,
    output logic             at_min
);

    localparam int c_NKEY     = 2 * NSTEP;
    localparam int c_KW       = (c_NKEY > 1) ? $clog2(c_NKEY) : 1;
    localparam int c_DBW      = $clog2(DEBOUNCE_CYC + 1);
    localparam int c_RPT_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int c_RW       = $clog2(c_RPT_MAX + 1);

    localparam logic [c_DBW-1:0] c_DB_LAST   = c_DBW'(DEBOUNCE_CYC - 1);
    localparam logic [c_RW-1:0]  c_HOLD_LAST = c_RW'(REPEAT_DELAY - 1);
    localparam logic [c_RW-1:0]  c_RATE_LAST = c_RW'(REPEAT_RATE - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_STEP   = 3'd1;
    localparam logic [2:0] c_S_HOLD   = 3'd2;
    localparam logic [2:0] c_S_STEP_R = 3'd3;
    localparam logic [2:0] c_S_RPT    = 3'd4;

    if ((WORD_MIN > WORD_INIT) || (WORD_INIT > WORD_MAX)) begin : g_param_err
        $error("dds_tuning_word_ctrl: WORD_MIN <= WORD_INIT <= WORD_MAX violated");
    end

    logic [c_NKEY-1:0] w_raw;
    logic [c_NKEY-1:0] w_stable;
    logic [c_NKEY-1:0] w_press;

    for (genvar i = 0; i < NSTEP; i++) begin : g_map
        assign w_raw[2*i]   = key_add_n[i];
        assign w_raw[2*i+1] = key_sub_n[i];
    end

    // Sync FFs reset to the pressed level: a key must be seen released after
    // reset (r_arm) before any debounced press is accepted.
    for (genvar k = 0; k < c_NKEY; k++) begin : g_key
        logic             r_s1, r_s2, r_stab, r_stab_d, r_arm;
        logic [c_DBW-1:0] r_cnt;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_s1     <= 1'b0;
                r_s2     <= 1'b0;
                r_stab   <= 1'b1;
                r_stab_d <= 1'b1;
                r_arm    <= 1'b0;
                r_cnt    <= '0;
            end else begin
                r_s1     <= w_raw[k];
                r_s2     <= r_s1;
                r_stab_d <= r_stab;
                if (r_stab && r_s2)
                    r_arm <= 1'b1;
                if (r_s2 == r_stab) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    r_stab <= r_s2;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        assign w_stable[k] = r_stab;
        assign w_press[k]  = r_arm & r_stab_d & ~r_stab;
    end

    logic [2:0]       r_state;
    logic [c_KW-1:0]  r_key;
    logic [c_RW-1:0]  r_rpt;
    logic [c_KW-1:0]  w_sel;
    logic [WIDTH-1:0] w_step;

    always_comb begin
        w_sel = '0;
        for (int k = c_NKEY - 1; k >= 0; k--)
            if (w_press[k]) w_sel = c_KW'(k);
    end

    always_comb begin
        w_step = '0;
        for (int i = 0; i < NSTEP; i++)
            if ((r_key >> 1) == c_KW'(i)) w_step = STEPS[i*WIDTH +: WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_key   <= '0;
            r_rpt   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (|w_press) begin
                        r_key   <= w_sel;
                        r_state <= c_S_STEP;
                    end
                end
                c_S_STEP: begin
                    r_rpt   <= '0;
                    r_state <= c_S_HOLD;
                end
                c_S_HOLD: begin
                    if (w_stable[r_key])          r_state <= c_S_IDLE;
                    else if (r_rpt == c_HOLD_LAST) r_state <= c_S_STEP_R;
                    else                           r_rpt   <= r_rpt + 1'b1;
                end
                c_S_STEP_R: begin
                    r_rpt   <= '0;
                    r_state <= c_S_RPT;
                end
                c_S_RPT: begin
                    if (w_stable[r_key])          r_state <= c_S_IDLE;
                    else if (r_rpt == c_RATE_LAST) r_state <= c_S_STEP_R;
                    else                           r_rpt   <= r_rpt + 1'b1;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    logic [WIDTH-1:0] r_word;
    logic             r_upd, r_at_max, r_at_min;
    logic [WIDTH:0]   w_sum, w_dif;
    logic [WIDTH-1:0] w_add_word, w_sub_word, w_load_word, w_next;
    logic             w_step_en;

    // One guard bit exposes both overflow and borrow so the word never wraps.
    assign w_sum       = {1'b0, r_word} + {1'b0, w_step};
    assign w_dif       = {1'b0, r_word} - {1'b0, w_step};
    assign w_add_word  = (w_sum > {1'b0, WORD_MAX}) ? WORD_MAX : w_sum[WIDTH-1:0];
    assign w_sub_word  = (w_dif[WIDTH] || (w_dif[WIDTH-1:0] < WORD_MIN)) ? WORD_MIN
                                                                         : w_dif[WIDTH-1:0];
    assign w_load_word = (load_word < WORD_MIN) ? WORD_MIN :
                         (load_word > WORD_MAX) ? WORD_MAX : load_word;
    assign w_step_en   = (r_state == c_S_STEP) || (r_state == c_S_STEP_R);
    assign w_next      = load      ? w_load_word :
                         w_step_en ? (r_key[0] ? w_sub_word : w_add_word) : r_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word   <= WORD_INIT;
            r_upd    <= 1'b0;
            r_at_max <= (WORD_INIT == WORD_MAX);
            r_at_min <= (WORD_INIT == WORD_MIN);
        end else begin
            r_word   <= w_next;
            r_upd    <= (w_next != r_word);
            r_at_max <= (w_next == WORD_MAX);
            r_at_min <= (w_next == WORD_MIN);
        end
    end

    assign tuning_word = r_word;
    assign word_upd    = r_upd;
    assign at_max      = r_at_max;
    assign at_min      = r_at_min;

endmodule
`default_nettype wire

// File: tb/tb_dds_tuning_word_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_tuning_word_ctrl
// Brief    : Directed + randomised bench for dds_tuning_word_ctrl against a
//            cycle-level behavioural model of keys, hold timing and clamping.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_tuning_word_ctrl;

    localparam int     NSTEP  = 3;
    localparam int     NK     = 2 * NSTEP;
    localparam int     DB     = 4;
    localparam int     RD     = 20;
    localparam int     RR     = 5;
    localparam longint W_INIT = 171798691;
    localparam longint W_MIN  = 858993;
    localparam longint W_MAX  = 171798691;

    longint step_tab [NSTEP] = '{858993, 85899, 85};

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [NSTEP-1:0] key_add_n = '1;
    logic [NSTEP-1:0] key_sub_n = '1;
    logic             load = 1'b0;
    logic [31:0]      load_word = '0;
    logic [31:0]      tuning_word;
    logic             word_upd, at_max, at_min;

    int checks = 0;
    int errors = 0;

    dds_tuning_word_ctrl #(
        .DEBOUNCE_CYC (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_RATE  (RR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_add_n   (key_add_n),
        .key_sub_n   (key_sub_n),
        .load        (load),
        .load_word   (load_word),
        .tuning_word (tuning_word),
        .word_upd    (word_upd),
        .at_max      (at_max),
        .at_min      (at_min)
    );

    always #5 clk = ~clk;

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic longint clampw(longint v);
        if (v < W_MIN) return W_MIN;
        if (v > W_MAX) return W_MAX;
        return v;
    endfunction

    function automatic longint apply_step(longint w, int k);
        longint s;
        s = step_tab[k/2];
        if (k % 2) return (w - s < W_MIN) ? W_MIN : w - s;
        return (w + s > W_MAX) ? W_MAX : w + s;
    endfunction

    // Behavioural model: values the outputs must hold after each clock edge.
    longint m_word;
    bit     m_upd;
    bit     sy1 [NK], sy2 [NK], stab [NK], armed [NK], pend [NK];
    int     run [NK];
    int     held, dcnt;
    bit     m_first;

    always @(posedge clk or posedge reset) begin
        longint nw;
        int     sel;
        bit     do_step, raw, np;
        if (reset) begin
            m_word = W_INIT;
            m_upd  = 1'b0;
            for (int k = 0; k < NK; k++) begin
                sy1[k] = 0; sy2[k] = 0; stab[k] = 1; armed[k] = 0; pend[k] = 0; run[k] = 0;
            end
            held = -1; dcnt = 0; m_first = 0;
        end else begin
            do_step = 0;
            nw      = m_word;
            if (held < 0) begin
                sel = -1;
                for (int k = NK - 1; k >= 0; k--) if (pend[k]) sel = k;
                if (sel >= 0) begin held = sel; dcnt = 1; m_first = 1; end
            end else if (dcnt == 1) begin
                do_step = 1;
                dcnt    = m_first ? RD + 1 : RR + 1;
                m_first = 0;
            end else if (stab[held]) begin
                held = -1;
            end else begin
                dcnt--;
            end
            if (do_step) nw = apply_step(m_word, held);
            if (load)    nw = clampw(longint'(load_word));
            m_upd  = (nw != m_word);
            m_word = nw;
            for (int k = 0; k < NK; k++) begin
                raw = (k % 2) ? key_sub_n[k/2] : key_add_n[k/2];
                np  = 0;
                if (stab[k] && sy2[k]) armed[k] = 1;
                if (sy2[k] != stab[k]) begin
                    run[k]++;
                    if (run[k] == DB) begin
                        if (stab[k] && armed[k]) np = 1;
                        stab[k] = ~stab[k];
                        run[k]  = 0;
                    end
                end else begin
                    run[k] = 0;
                end
                pend[k] = np;
                sy2[k]  = sy1[k];
                sy1[k]  = raw;
            end
        end
    end

    always @(negedge clk) begin
        check("word", tuning_word, m_word);
        check("word_upd", word_upd, m_upd);
        check("at_max", at_max, m_word == W_MAX);
        check("at_min", at_min, m_word == W_MIN);
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic set_key(int k, bit v);
        if (k % 2) key_sub_n[k/2] = v;
        else       key_add_n[k/2] = v;
    endtask

    task automatic do_load(longint v);
        load      = 1'b1;
        load_word = v[31:0];
        tick(1);
        load      = 1'b0;
    endtask

    initial begin
        tick(3);
        reset = 1'b0;
        tick(2);
        // idle after reset
        check("t1_word", tuning_word, 171798691);
        check("t1_at_max", at_max, 1);
        check("t1_at_min", at_min, 0);
        check("t1_upd", word_upd, 0);

        // nano sub held: steps at edges 8, 29, 35, 41, 47
        set_key(5, 0);
        tick(10); check("t2_first", tuning_word, 171798606);
        tick(20); check("t2_rpt1", tuning_word, 171798521);
        tick(6);  check("t2_rpt2", tuning_word, 171798436);
        tick(4);
        set_key(5, 1);
        tick(30); check("t2_released", tuning_word, 171798266);

        // add at the upper clamp
        do_load(W_MAX);
        set_key(0, 0);
        tick(12);
        check("t3_word", tuning_word, 171798691);
        check("t3_at_max", at_max, 1);
        check("t3_upd", word_upd, 0);
        set_key(0, 1);
        tick(12);

        // sub clamps to lower bound
        do_load(900000);
        check("t4_load", tuning_word, 900000);
        set_key(1, 0); tick(10);
        check("t4_clamp", tuning_word, 858993);
        check("t4_at_min", at_min, 1);
        set_key(1, 1); tick(12);
        set_key(1, 0); tick(10);
        check("t4_again", tuning_word, 858993);
        set_key(1, 1); tick(12);

        // bounce shorter than the debounce window
        for (int i = 0; i < 5; i++) begin
            set_key(2, 0); tick(2);
            set_key(2, 1); tick(2);
        end
        tick(12);
        check("t5_bounce", tuning_word, 858993);
        do_load(50000000);
        set_key(2, 0); set_key(1, 0);
        tick(10);
        check("t5_prio", tuning_word, 49141007);
        set_key(2, 1); set_key(1, 1);
        tick(12);

        // reset while auto-repeating; held key must be re-pressed
        set_key(3, 0);
        tick(35);
        reset = 1'b1;
        #1;
        check("t6_reset", tuning_word, 171798691);
        tick(2);
        reset = 1'b0;
        tick(40);
        check("t6_held", tuning_word, 171798691);
        set_key(3, 1); tick(12);
        set_key(3, 0); tick(10);
        check("t6_repress", tuning_word, 171712792);
        set_key(3, 1); tick(12);

        // randomised episodes
        for (int e = 0; e < 40; e++) begin
            int k, nb, hold;
            k  = $urandom_range(0, NK - 1);
            nb = $urandom_range(0, 6);
            for (int b = 0; b < nb; b++) begin
                set_key(k, 1'($urandom_range(0, 1)));
                tick($urandom_range(1, 3));
            end
            set_key(k, 0);
            if ($urandom_range(0, 3) == 0) set_key($urandom_range(0, NK - 1), 0);
            hold = $urandom_range(2, 45);
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 15) == 0) begin
                    load      = 1'b1;
                    load_word = ($urandom_range(0, 3) == 0) ? $urandom
                                                            : 32'($urandom_range(0, 180000000));
                end else begin
                    load = 1'b0;
                end
                tick(1);
            end
            load      = 1'b0;
            key_add_n = '1;
            key_sub_n = '1;
            tick($urandom_range(8, 20));
            if ($urandom_range(0, 9) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
                tick(3);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
